// File: rtl/sequence_generator_if.sv
// rtl/sequence_generator_if.sv - control and symbol-stream bundle for sequence_generator
//
// Purpose: groups the burst-control inputs and the symbol outputs of
//          sequence_generator so they travel as one port.
// Signals:
//   start        - request a burst (honoured only while idle)
//   repeat_count - number of pattern copies, 0 behaves as 1
//   gap          - idle cycles between copies
//   inject_error - corrupt the final symbol of the final copy
//   abort        - terminate the current burst
//   data         - current 3-bit symbol
//   data_valid   - data holds a pattern symbol
//   busy         - burst in progress
//   done         - one-cycle pulse after a normal completion
// Modports: master drives control and observes the stream; slave is the generator.
interface sequence_generator_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] repeat_count;
    logic [3:0]       gap;
    logic             inject_error;
    logic             abort;
    logic [2:0]       data;
    logic             data_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, repeat_count, gap, inject_error, abort,
        input  data, data_valid, busy, done
    );

    modport slave (
        input  start, repeat_count, gap, inject_error, abort,
        output data, data_valid, busy, done
    );
endinterface

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - repeating 8-symbol pattern source with gaps, abort and error injection
//
// Purpose: on start, sends 001,101,110,000,110,110,011,101 one symbol per
//          clock, repeated a captured number of times with a captured idle
//          gap between copies. The final symbol of the final copy may be
//          forced to 000 to exercise a downstream detector's negative path.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - sequence_generator_if slave (control in, symbol stream out)
// All outputs come straight from flops; next-state and next-output values
// are computed together so each output reflects the state being entered.
module sequence_generator #(
    parameter int         CNT_W       = 4,
    parameter logic [2:0] IDLE_SYMBOL = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sequence_generator_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [2:0]       idx_q,      idx_d;
    logic [CNT_W-1:0] copies_q,   copies_d;
    logic [3:0]       gap_cnt_q,  gap_cnt_d;
    logic [3:0]       gap_lat_q,  gap_lat_d;
    logic             inj_q,      inj_d;
    logic [2:0]       data_q,     data_d;
    logic             valid_q,    valid_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    function automatic logic [2:0] pattern_sym(input logic [2:0] i);
        logic [2:0] s;
        case (i)
            3'd0:    s = 3'b001;
            3'd1:    s = 3'b101;
            3'd2:    s = 3'b110;
            3'd3:    s = 3'b000;
            3'd4:    s = 3'b110;
            3'd5:    s = 3'b110;
            3'd6:    s = 3'b011;
            default: s = 3'b101;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        copies_d  = copies_q;
        gap_cnt_d = gap_cnt_q;
        gap_lat_d = gap_lat_q;
        inj_d     = inj_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    gap_lat_d = bus.gap;
                    inj_d     = bus.inject_error;
                    copies_d  = (bus.repeat_count == '0) ? CNT_W'(1) : bus.repeat_count;
                    idx_d     = 3'd0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == 3'd7) begin
                    if (copies_q > CNT_W'(1)) begin
                        copies_d = copies_q - CNT_W'(1);
                        idx_d    = 3'd0;
                        if (gap_lat_q != 4'd0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_lat_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == 4'd1) begin
                    // Counter was loaded with the gap length, so reaching 1
                    // marks the last idle cycle of the gap.
                    state_d = ST_SEND;
                    idx_d   = 3'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        data_d  = IDLE_SYMBOL;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (state_d == ST_SEND) begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            // Corruption only on the very last symbol of the burst.
            data_d  = (inj_d && idx_d == 3'd7 && copies_d == CNT_W'(1))
                      ? 3'b000 : pattern_sym(idx_d);
        end else if (state_d == ST_GAP) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            copies_q  <= '0;
            gap_cnt_q <= 4'd0;
            gap_lat_q <= 4'd0;
            inj_q     <= 1'b0;
            data_q    <= IDLE_SYMBOL;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            copies_q  <= copies_d;
            gap_cnt_q <= gap_cnt_d;
            gap_lat_q <= gap_lat_d;
            inj_q     <= inj_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Transmit-side companion to the 3-bit `SequenceDetector`. On a start pulse it drives the 8-symbol pattern 001, 101, 110, 000, 110, 110, 011, 101 onto a 3-bit data bus, one symbol per clock. The pattern is sent a programmable number of times, with a programmable idle gap between copies. Optional error injection corrupts the final symbol. The block feeds detector benches and the on-chip loopback path.

## Interface
- `CNT_W`, default 4: width of the repeat counter.
- `IDLE_SYMBOL`, default 3'b000: value driven on `data` whenever `data_valid` is low.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request a burst; honoured only in IDLE.
- `repeat_count`, in, CNT_W: number of pattern copies; 0 is treated as 1; captured at start.
- `gap`, in, 4: idle cycles between copies (0–15); captured at start.
- `inject_error`, in, 1: captured at start; if set, the final symbol of the final copy is sent as 3'b000 instead of 3'b101.
- `abort`, in, 1: terminates the burst immediately.
- `data`, out, 3: current symbol.
- `data_valid`, out, 1: `data` holds a pattern symbol this cycle.
- `busy`, out, 1: high in SEND and GAP.
- `done`, out, 1: one-cycle pulse after a burst completes normally.

## Operation
- **States:** IDLE, SEND, GAP.
- **Registers:**
  - symbol index `idx` (3 bits, 0–7)
  - copies-remaining counter (CNT_W bits)
  - gap counter (4 bits)
  - latched `gap` and `inject_error` values
  - registered outputs
- **IDLE:**
  - Outputs: `data`=IDLE_SYMBOL, `data_valid`=0, `busy`=0.
  - `start`=1 latches the config, sets copies = max(`repeat_count`,1), sets idx=0, and enters SEND.
- **SEND:**
  - Outputs: `data`=pattern[idx], `data_valid`=1, `busy`=1. idx increments each cycle.
  - At idx=7 with copies remaining > 1: decrement copies and set idx=0.
    - If latched gap > 0, go to GAP with the gap counter set to gap.
    - Otherwise stay in SEND, so the next copy follows back-to-back.
  - At idx=7 with copies remaining = 1: go to IDLE and pulse `done` in the following cycle.
- **GAP:**
  - Outputs: `data`=IDLE_SYMBOL, `data_valid`=0, `busy`=1.
  - The gap counter decrements each cycle. When it expires, return to SEND with idx=0.
- **Error injection:** applies only when idx=7 on the last copy. Earlier copies are always correct.
- **abort** (sampled in SEND or GAP):
  - Highest priority.
  - Next cycle: IDLE, `data_valid`=0, `busy`=0, `data`=IDLE_SYMBOL.
  - `done` is not asserted.
- **start** in SEND or GAP is ignored, as is `start` in the same cycle as `abort` while busy. `repeat_count`, `gap` and `inject_error` changes mid-burst have no effect.
- **Same-cycle `done` and `start`:** `start` is accepted in the cycle `done` is high, because the state is already IDLE.

## Timing
- **Reset:** asynchronous assertion forces `data`=IDLE_SYMBOL, `data_valid`=0, `busy`=0, `done`=0, state IDLE, and clears all counters. Reset mid-burst abandons the burst with no `done`. Deassertion is followed by IDLE.
- **Latency:**
  - `start` sampled at edge N gives the first symbol 001 valid after edge N, i.e. visible in cycle N+1.
  - One copy with no gap: valid in cycles N+1..N+8, `done`=1 in cycle N+9, `busy` low from cycle N+9.
- **Burst length:** R copies with gap G take 8R + G(R−1) cycles from the first symbol to the last symbol. `done` follows one cycle later.
- **Throughput:** back-to-back bursts restart with the first symbol in cycle N+10, i.e. one idle cycle between bursts.
- **Output registering:** all outputs are registered, with no combinational path from inputs to outputs. Symbols are stable across each full clock period, so the detector samples them on the next edge.

## Test plan
- **Single copy:** reset, then `start` with `repeat_count`=1, `gap`=0.
  - `data_valid`=1 for exactly 8 cycles, with `data`=001,101,110,000,110,110,011,101.
  - `done` is one pulse in the following cycle.
  - A connected `SequenceDetector` asserts `sequence_found`.
- **Back-to-back:** `repeat_count`=2, `gap`=0.
  - 16 consecutive valid symbols (the pattern twice).
  - `busy`=1 for 16 cycles and a single `done` pulse.
- **Gap:** `repeat_count`=2, `gap`=3.
  - 8 valid symbols, then 3 cycles with `data_valid`=0 and `data`=000 while `busy`=1, then 8 valid symbols, then `done`.
- **Error injection:** `repeat_count`=2, `inject_error`=1.
  - The first copy is intact.
  - The last symbol of the second copy is 000, not 101.
  - The detector fires after copy 1 only.
- **Abort:** `abort` during the fourth symbol.
  - Next cycle: `data_valid`=0, `busy`=0, `data`=000.
  - `done` is never asserted.
  - A new `start` is then accepted and produces the full pattern.
- **Reset and ignored start:**
  - `reset_n` pulled low mid-GAP: outputs clear immediately (asynchronous) with no `done`.
  - `start` pulsed during SEND is ignored, so the symbol count is unchanged.
  - `repeat_count`=0 produces exactly one copy.
